// File: rtl/vdot_reduce.sv
// vdot_reduce: folds a 16-lane binary16 product vector into one scalar,
// adding one lane per cycle (left fold from +0, lane 0 first), and hands the
// result plus destination tag to writeback.
// Optional build macro: VDOT_ZERO_SKIP_EN -- skip lanes whose magnitude is
// zero, so latency becomes max(N,1) cycles for N nonzero lanes.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and data is held while valid && !ready.
module vdot_reduce #(
   parameter int LANES  = 16,
   parameter int LANE_W = 16,
   parameter int TAG_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*LANE_W-1:0] in_vec,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANE_W-1:0]       out_result,
   output logic [TAG_W-1:0]        out_tag,
   output logic                    busy
);

   localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                  state, state_next;
   logic [LANES*LANE_W-1:0] vec_r;
   logic [TAG_W-1:0]        tag_r;
   logic [LANE_W-1:0]       acc, lane, sum;
   logic                    accept, add_en, last;

   // binary16 add, round-to-nearest-even with subnormals. Finite operands are
   // turned into exact integers in units of 2^-24 (41 bits covers 2*65504), so
   // the sum is exact and only one rounding step is needed. NaN results are the
   // canonical quiet NaN 7E00; an exact cancellation yields +0, while -0 + -0
   // stays -0.
   function automatic logic [15:0] float_add(input logic [15:0] a, input logic [15:0] b);
      logic [4:0]  ea, eb;
      logic [40:0] ma, mb, mag, rest;
      logic [11:0] sig_r;
      logic        sr, guard, sticky;
      logic [15:0] res;
      int          sh_a, sh_b, lead, sh;
      ea = a[14:10];
      eb = b[14:10];
      res = 16'h0000;
      if ((ea == 5'h1F && a[9:0] != 10'd0) || (eb == 5'h1F && b[9:0] != 10'd0) ||
          (ea == 5'h1F && eb == 5'h1F && a[15] != b[15])) begin
         res = 16'h7E00;
      end else if (ea == 5'h1F) begin
         res = a;
      end else if (eb == 5'h1F) begin
         res = b;
      end else begin
         sh_a = (ea == 5'd0) ? 0 : int'(ea) - 1;
         sh_b = (eb == 5'd0) ? 0 : int'(eb) - 1;
         ma = 41'({(ea != 5'd0), a[9:0]}) << sh_a;
         mb = 41'({(eb != 5'd0), b[9:0]}) << sh_b;
         if (a[15] == b[15]) begin
            mag = ma + mb;
            sr  = a[15];
         end else if (ma >= mb) begin
            mag = ma - mb;
            sr  = a[15];
         end else begin
            mag = mb - ma;
            sr  = b[15];
         end
         if (mag == 41'd0) begin
            res = {a[15] & b[15], 15'h0000};
         end else if (mag < 41'd2048) begin
            // Below 2^-13 every value is exact and its encoding is the integer itself.
            res = {sr, mag[14:0]};
         end else begin
            lead = 0;
            for (int i = 0; i < 41; i++) begin
               if (mag[i]) lead = i;
            end
            sh     = lead - 10;
            rest   = mag >> (sh - 1);
            guard  = rest[0];
            sticky = |(mag & ((41'd1 << (sh - 1)) - 41'd1));
            sig_r  = {1'b0, 11'(mag >> sh)};
            if (guard && (sticky || sig_r[0])) sig_r = sig_r + 12'd1;
            if (sig_r[11]) begin
               sig_r = 12'd1024;
               sh    = sh + 1;
            end
            if (sh + 1 >= 31) res = {sr, 15'h7C00};
            else              res = {sr, 5'(sh + 1), sig_r[9:0]};
         end
      end
      return res;
   endfunction

`ifdef VDOT_ZERO_SKIP_EN
   logic [LANES-1:0] mask_r, mask_next, nz_mask;
   logic [IDX_W-1:0] sel;

   // Pick the lowest pending nonzero lane and build the capture-time mask.
   always_comb begin
      sel = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (mask_r[i]) sel = IDX_W'(i);
      end
      nz_mask = '0;
      for (int i = 0; i < LANES; i++) begin
         nz_mask[i] = |in_vec[i*LANE_W +: LANE_W-1];
      end
      mask_next = mask_r & ~(LANES'(1) << sel);
      add_en    = |mask_r;
      last      = (mask_next == '0);
      lane      = vec_r[LANE_W*int'(sel) +: LANE_W];
      sum       = add_en ? float_add(acc, lane) : acc;
   end
`else
   logic [IDX_W-1:0] idx;

   // Fixed walk over every lane in order.
   always_comb begin
      add_en = 1'b1;
      last   = (idx == IDX_W'(LANES - 1));
      lane   = vec_r[LANE_W*int'(idx) +: LANE_W];
      sum    = float_add(acc, lane);
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and handshake outputs; flush forces IDLE from any state.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = ACCUM;
         end
         ACCUM: begin
            busy = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = !flush;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
      accept = in_valid && in_ready && !flush;
   end

   // Datapath: capture on accept, accumulate in ACCUM, load outputs on the last add.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_r      <= '0;
         tag_r      <= '0;
         acc        <= '0;
         out_result <= '0;
         out_tag    <= '0;
`ifdef VDOT_ZERO_SKIP_EN
         mask_r     <= '0;
`else
         idx        <= '0;
`endif
      end else if (accept) begin
         vec_r  <= in_vec;
         tag_r  <= in_tag;
         acc    <= '0;
`ifdef VDOT_ZERO_SKIP_EN
         mask_r <= nz_mask;
`else
         idx    <= '0;
`endif
      end else if (state == ACCUM && !flush) begin
         acc    <= sum;
`ifdef VDOT_ZERO_SKIP_EN
         mask_r <= mask_next;
`else
         idx    <= idx + IDX_W'(1);
`endif
         if (last) begin
            out_result <= sum;
            out_tag    <= tag_r;
         end
      end
   end

endmodule
